// File: rtl/data_ram_responder.sv
// data_ram_responder: responder end of the EXE-stage data-RAM request
// interface. Returns registered read data one clock after the request so the
// value is stable while the instruction sits in MEM. After reset a hardware
// sweep writes INIT_VALUE to every word; data_ram_ready rises when it is done.
//
// Optional build macro: DRAM_BYTE_WE_EN
//   defined   -> the four byte enables act independently (partial writes)
//   undefined -> only data_ram_w_en_4bit[0] is used; it writes the whole word
//
// Ports:
//   clk                 clock, rising edge
//   reset               asynchronous, active-low reset
//   data_ram_en         request valid this cycle
//   data_ram_w_en_4bit  byte write enables (bit i -> w_data[8i+7:8i])
//   data_ram_addr       byte address; [1:0] ignored, upper bits must be zero
//   data_ram_w_data     write data
//   data_ram_r_data     registered read data, holds when no read is accepted
//   data_ram_ready      high once the clear sweep has finished
//   data_ram_addr_err   one-cycle pulse after a dropped out-of-range request
module data_ram_responder #(
  parameter int unsigned ADDR_WD    = 10,
  parameter logic [31:0] INIT_VALUE = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_ram_en,
  input  logic [3:0]  data_ram_w_en_4bit,
  input  logic [31:0] data_ram_addr,
  input  logic [31:0] data_ram_w_data,
  output logic [31:0] data_ram_r_data,
  output logic        data_ram_ready,
  output logic        data_ram_addr_err
);

  localparam int unsigned DEPTH  = 1 << ADDR_WD;
  localparam int unsigned CLR_WD = ADDR_WD + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CLR_WD-1:0]   clr_idx;
  logic [31:0]         mem [DEPTH];

  logic [ADDR_WD-1:0]  word_idx_c;
  logic                in_range_c;
  logic                sweep_last_c;
  logic                sweep_we_c;
  logic                accept_c;
  logic                err_c;
  logic [3:0]          byte_we_c;
  logic                unused_bits;

  // Address decode
  assign word_idx_c   = data_ram_addr[ADDR_WD+1:2];
  assign in_range_c   = (data_ram_addr[31:ADDR_WD+2] == '0);
  assign sweep_last_c = (clr_idx == CLR_WD'(DEPTH - 1));

  // Byte-lane write mask for an accepted request
`ifdef DRAM_BYTE_WE_EN
  assign byte_we_c   = data_ram_w_en_4bit;
  assign unused_bits = ^data_ram_addr[1:0];
`else
  assign byte_we_c   = {4{data_ram_w_en_4bit[0]}};
  assign unused_bits = ^{data_ram_addr[1:0], data_ram_w_en_4bit[3:1]};
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: leave INIT once the last word has been cleared
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (sweep_last_c) state_nxt = ST_IDLE;
      ST_IDLE: state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Per-state controls; requests are ignored entirely during the sweep
  always_comb begin
    sweep_we_c = 1'b0;
    accept_c   = 1'b0;
    err_c      = 1'b0;
    case (state)
      ST_INIT: sweep_we_c = 1'b1;
      ST_IDLE: begin
        accept_c = data_ram_en && in_range_c;
        err_c    = data_ram_en && !in_range_c;
      end
      default: ;
    endcase
  end

  // Clear counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_idx <= '0;
    end else if (sweep_we_c) begin
      clr_idx <= clr_idx + CLR_WD'(1);
    end
  end

  // Registered outputs; r_data holds unless a read is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_ram_r_data   <= 32'h0;
      data_ram_ready    <= 1'b0;
      data_ram_addr_err <= 1'b0;
    end else begin
      if (accept_c) begin
        data_ram_r_data <= mem[word_idx_c];
      end
      data_ram_ready    <= (state_nxt == ST_IDLE);
      data_ram_addr_err <= err_c;
    end
  end

  // Storage array: not reset; the sweep initialises it. Reading above uses the
  // pre-edge contents, so a same-word read+write returns the old data.
  always_ff @(posedge clk) begin
    if (sweep_we_c) begin
      mem[clr_idx[ADDR_WD-1:0]] <= INIT_VALUE;
    end else if (accept_c) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_we_c[b]) begin
          mem[word_idx_c][8*b +: 8] <= data_ram_w_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed, table-driven bench for data_ram_responder (ADDR_WD=4, DEPTH=16).
module tb_data_ram_responder;

  localparam int unsigned ADDR_WD = 4;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned NVEC    = 18;

  logic        clk;
  logic        reset;
  logic        data_ram_en;
  logic [3:0]  data_ram_w_en_4bit;
  logic [31:0] data_ram_addr;
  logic [31:0] data_ram_w_data;
  logic [31:0] data_ram_r_data;
  logic        data_ram_ready;
  logic        data_ram_addr_err;

  int n_cmp;
  int n_bad;

  data_ram_responder #(
    .ADDR_WD    (ADDR_WD),
    .INIT_VALUE (32'h0)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .data_ram_en        (data_ram_en),
    .data_ram_w_en_4bit (data_ram_w_en_4bit),
    .data_ram_addr      (data_ram_addr),
    .data_ram_w_data    (data_ram_w_data),
    .data_ram_r_data    (data_ram_r_data),
    .data_ram_ready     (data_ram_ready),
    .data_ram_addr_err  (data_ram_addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_r;
    logic        exp_err;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    data_ram_en        = en;
    data_ram_w_en_4bit = we;
    data_ram_addr      = addr;
    data_ram_w_data    = wdata;
  endtask

  // One rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdata"}, data_ram_r_data, 32'h0);
    chk({tag, "_ready"}, 32'(data_ram_ready), 32'h0);
    chk({tag, "_err"},   32'(data_ram_addr_err), 32'h0);
  endtask

  // Counts edges after release; ready must be low through edge DEPTH-1
  task automatic sweep_check(input string tag);
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      if (k < DEPTH) begin
        chk({tag, "_ready_low"}, 32'(data_ram_ready), 32'h0);
      end else begin
        chk({tag, "_ready_high"}, 32'(data_ram_ready), 32'h1);
      end
      chk({tag, "_rdata_zero"}, data_ram_r_data, 32'h0);
      chk({tag, "_err_low"}, 32'(data_ram_addr_err), 32'h0);
    end
  endtask

  initial begin
    logic [31:0] exp_partial;
    n_cmp = 0;
    n_bad = 0;

`ifdef DRAM_BYTE_WE_EN
    exp_partial = 32'hDE22BE44;
`else
    exp_partial = 32'h11223344;
`endif

    //            en    we     addr          wdata         exp_r         err
    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0008, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 4'h0, 32'h0000_0008, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 4'hF, 32'h0000_0008, 32'h5555_5555, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 32'h0000_0004, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[5]  = '{1'b1, 4'h5, 32'h0000_0008, 32'h11223344, 32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b1, 4'h0, 32'h0000_0008, 32'h0,        exp_partial,  1'b0};
    vecs[7]  = '{1'b1, 4'hF, 32'h0000_0004, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, 4'h0, 32'h0000_0004, 32'h0,        32'h0000_0001, 1'b0};
    vecs[9]  = '{1'b1, 4'hF, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
    vecs[10] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,        32'h0000_0001, 1'b0};
    vecs[11] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b0};
    vecs[12] = '{1'b1, 4'hF, 32'h0000_003E, 32'hCAFEF00D, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b1, 4'h0, 32'h0000_003C, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[14] = '{1'b1, 4'h0, 32'h0000_1000, 32'h0,        32'hCAFEF00D, 1'b1};
    vecs[15] = '{1'b1, 4'hF, 32'h8000_0000, 32'h1234_5678, 32'hCAFEF00D, 1'b1};
    vecs[16] = '{1'b0, 4'h0, 32'h0,         32'h0,        32'hCAFEF00D, 1'b0};
    vecs[17] = '{1'b1, 4'h0, 32'h0000_0030, 32'h0,        32'hFFFF_FFFF, 1'b0};

    // Reset with a write request presented throughout the sweep
    reset = 1'b0;
    drive(1'b1, 4'hF, 32'h0000_0030, 32'hFFFF_FFFF);
    #23;
    chk_reset_vals("por");
    reset = 1'b1;
    #1;
    sweep_check("sweep1");

    // Edge DEPTH+1: first accepted request (write word 12, read-first -> 0)
    step();
    chk("first_accept_rdata", data_ram_r_data, 32'h0);
    chk("first_accept_err", 32'(data_ram_addr_err), 32'h0);

    // Table vectors, one edge each
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      step();
      chk($sformatf("vec%0d_rdata", i), data_ram_r_data, vecs[i].exp_r);
      chk($sformatf("vec%0d_err", i), 32'(data_ram_addr_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_ready", i), 32'(data_ram_ready), 32'h1);
    end

    // Reset while err pulses and r_data is nonzero: clears asynchronously
    drive(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    step();
    chk("pre_rst_err", 32'(data_ram_addr_err), 32'h1);
    chk("pre_rst_rdata", data_ram_r_data, 32'hFFFF_FFFF);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    drive(1'b1, 4'h0, 32'h0000_0008, 32'h0);
    #10;
    reset = 1'b1;

    // Abort the sweep after 7 edges
    for (int k = 0; k < 7; k++) begin
      step();
      chk("mid_sweep_ready_low", 32'(data_ram_ready), 32'h0);
    end
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("mid_sweep_rst");
    #10;
    reset = 1'b1;
    #1;
    sweep_check("sweep2");

    // Word 8 held DEADBEEF-derived data before; the sweep must have cleared it
    step();
    chk("post_sweep_read8", data_ram_r_data, 32'h0);
    drive(1'b1, 4'hF, 32'h0000_0008, 32'hA5A5_5A5A);
    step();
    drive(1'b1, 4'h0, 32'h0000_0008, 32'h0);
    step();
    chk("post_sweep_rw8", data_ram_r_data, 32'hA5A5_5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

- Responder end of the data-RAM request interface that the EXE stage drives.
- Accepts the EXE-stage request and returns registered read data one clock later, so the value is valid while the instruction sits in MEM.
- Models the data RAM with byte write enables and an out-of-range error flag.
- After reset, runs a hardware sweep that clears the whole array, and signals readiness when the sweep is done.

## Interface

Parameters:
- ADDR_WD, 10, word-index width; DEPTH = 2^ADDR_WD 32-bit words
- INIT_VALUE, 32'h0, value written to every word by the post-reset sweep

Ports:
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  reset, asynchronous and active-low
- data_ram_en  in  1  request valid this cycle
- data_ram_w_en_4bit  in  4  byte write enables; bit i covers w_data[8i+7:8i]
- data_ram_addr  in  32  byte address
- data_ram_w_data  in  32  write data
- data_ram_r_data  out  32  registered read data
- data_ram_ready  out  1  high once the clear sweep has finished
- data_ram_addr_err  out  1  one-cycle pulse for a dropped out-of-range request

## Operation

Address decode:
- Word index = data_ram_addr[ADDR_WD+1:2].
- data_ram_addr[1:0] is ignored.
- A request is out of range when data_ram_addr[31:ADDR_WD+2] != 0.

State machine, states INIT and IDLE:
- INIT
  - The clear counter clr_idx (ADDR_WD+1 bits) writes INIT_VALUE to mem[clr_idx] on each edge, then increments.
  - When the word at clr_idx == DEPTH-1 is written, the state moves to IDLE.
  - All requests are ignored: no read, no write, no error pulse.
- IDLE
  - A request is accepted when data_ram_en=1 and it is in range.
  - Read: data_ram_r_data <= mem[index] at the edge.
  - Write: at the same edge, each byte with its enable set is updated.
  - Read-first: a simultaneous read and write to the same word returns the pre-write data; the written value is visible to the next access.
- Idle request (data_ram_en=0): data_ram_r_data holds its last value, so the MEM stage can stall without losing load data.
- Out-of-range request (data_ram_en=1) in IDLE:
  - Nothing is written and data_ram_r_data holds.
  - data_ram_addr_err=1 for exactly the following cycle.
- Back-to-back requests are accepted every cycle with no bubbles.

Reset (reset low):
- Asynchronously: state=INIT, clr_idx=0, data_ram_r_data=0, data_ram_ready=0, data_ram_addr_err=0.
- Array contents are not reset asynchronously; the sweep clears them.
- Reset asserted mid-sweep or mid-operation aborts immediately. The sweep restarts from index 0 after release.

## Timing

- Read latency is 1 cycle: request at edge N, data valid after edge N until the next accepted read.
- Write takes effect at the request edge.
- Sweep:
  - The first rising edge with reset high clears word 0.
  - Edge k clears word k-1.
  - Edge DEPTH clears the last word and sets data_ram_ready=1, registered.
  - The first request accepted is the one presented at edge DEPTH+1.
- data_ram_ready stays 1 until the next reset assertion.
- data_ram_addr_err is registered and goes low on the next edge unless another out-of-range request arrives.

## Configuration

- DRAM_BYTE_WE_EN defined: the four byte enables act independently (sb/sh-style partial writes).
- DRAM_BYTE_WE_EN undefined:
  - Only data_ram_w_en_4bit[0] is examined.
  - When it is set, the full 32-bit word is written; bits [3:1] are ignored.
- Reads, the sweep and the error flag are identical in both builds.

## Test plan

All scenarios use ADDR_WD=4 (DEPTH=16).
- Reset release with data_ram_en=1 throughout -> data_ram_ready=0 for 15 cycles and rises after edge 16; r_data=0 throughout; no writes occur.
- After ready:
  - Write 32'hDEADBEEF with w_en=4'hF to addr 0x8.
  - Read 0x8 on the next cycle -> r_data=32'hDEADBEEF one cycle later.
  - Hold en=0 for 3 cycles -> r_data unchanged.
- With DRAM_BYTE_WE_EN, word 0x8 = 32'hDEADBEEF:
  - Write 32'h11223344 with w_en=4'b0101 -> read gives 32'hDE22BE44.
  - Without the macro, same stimulus -> 32'h11223344.
- Simultaneous write of 32'h1 and read to 0x4 holding 32'h0 -> r_data=32'h0; the next read returns 32'h1.
- Write to addr 0x40 (out of range) -> addr_err high exactly one cycle; r_data held; a subsequent read of 0x0 returns INIT_VALUE.
- Assert reset at sweep cycle 7 -> outputs return to reset values immediately; after release, ready rises 16 edges later.
